// File: rtl/uart_alu_intf_pkg.sv
// Shared UART/ALU definitions: frame FSM encoding, default data widths and
// the sizing helper for the inter-byte timer.
package uart_alu_intf_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } frame_state_t;

    // Bits needed to hold the values 0..limit, never less than one bit.
    function automatic int timer_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_alu_intf_if.sv
// Bundle of the UART receive/transmit handshakes and the ALU operand/result
// bus. The master side is the frame controller; the slave side is the
// surrounding UART and ALU logic.
interface uart_alu_intf_if
    import uart_alu_intf_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done_tick;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done_tick;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_drop_tick;

    modport master (
        input  i_rx_data, i_rx_done_tick, i_alu_result, i_tx_done_tick,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_drop_tick
    );

    modport slave (
        output i_rx_data, i_rx_done_tick, i_alu_result, i_tx_done_tick,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_drop_tick
    );
endinterface

// File: rtl/uart_alu_intf_frame_timer.sv
// Saturating inter-byte timer. Counts clocks while enabled, restarts from
// zero on clear, and flags expiry once TIMEOUT_CYCLES clocks have elapsed.
module frame_timer
    import uart_alu_intf_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int            TW    = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] count_q;

    // Count up while enabled, holding at the limit instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/uart_alu_intf.sv
// Frame controller between a UART and a combinational ALU: collects the
// A, B and opcode bytes, executes for one clock, hands the result to the
// transmitter and waits for it to finish. Bytes arriving while a result is
// in flight are dropped and reported; a stalled partial frame times out.
module uart_alu_intf
    import uart_alu_intf_pkg::*;
#(
    parameter int NB_DATA        = NB_DATA_DEF,
    parameter int NB_OP          = NB_OP_DEF,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    uart_alu_intf_if.master bus
);
    frame_state_t       state_q, state_d;
    logic               load_a, load_b, load_op, load_tx, drop;
    logic               timer_run, timer_clear, timer_expired;

    logic [NB_DATA-1:0] alu_a_q, alu_b_q, tx_data_q;
    logic [NB_OP-1:0]   alu_op_q;
    logic               tx_start_q, drop_tick_q;

    // The timer only runs while a frame is partially received; it restarts
    // whenever a byte is accepted and is held at zero in every other state.
    assign timer_run   = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign timer_clear = !timer_run || bus.i_rx_done_tick;

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .clear   (timer_clear),
        .enable  (timer_run),
        .expired (timer_expired)
    );

    // Frame state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and load decisions; a received byte outranks a timeout.
    always_comb begin
        state_d = state_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_op = 1'b0;
        load_tx = 1'b0;
        drop    = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (bus.i_rx_done_tick) begin
                    load_a  = 1'b1;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.i_rx_done_tick) begin
                    load_b  = 1'b1;
                    state_d = WAIT_OP;
                end else if (timer_expired) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done_tick) begin
                    load_op = 1'b1;
                    state_d = EXEC;
                end else if (timer_expired) begin
                    state_d = WAIT_A;
                end
            end
            EXEC: begin
                load_tx = 1'b1;
                drop    = bus.i_rx_done_tick;
                state_d = SEND;
            end
            SEND: begin
                drop    = bus.i_rx_done_tick;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                drop = bus.i_rx_done_tick;
                if (bus.i_tx_done_tick) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // Operand, opcode and result registers; they hold until the next frame
    // overwrites them. The start request is high exactly while in SEND.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            drop_tick_q <= 1'b0;
        end else begin
            if (load_a)  alu_a_q   <= bus.i_rx_data;
            if (load_b)  alu_b_q   <= bus.i_rx_data;
            if (load_op) alu_op_q  <= bus.i_rx_data[NB_OP-1:0];
            if (load_tx) tx_data_q <= bus.i_alu_result;
            tx_start_q  <= load_tx;
            drop_tick_q <= drop;
        end
    end

    assign bus.o_alu_a     = alu_a_q;
    assign bus.o_alu_b     = alu_b_q;
    assign bus.o_alu_op    = alu_op_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_drop_tick = drop_tick_q;

endmodule
